// File: rtl/pipeline_reg_s2_s3.sv
// ID/EX pipeline register: carries decoded S2 fields into S3, inserting bubbles on
// load-use hazards and flushes, freezing on memory hold, with saturating event counters.
module pipeline_reg_s2_s3 #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] PC_S2,
  input  logic [DATA_WIDTH-1:0] DATA1_S2,
  input  logic [DATA_WIDTH-1:0] DATA2_S2,
  input  logic [DATA_WIDTH-1:0] IMM_S2,
  input  logic [4:0]            ADDR1_S2,
  input  logic [4:0]            ADDR2_S2,
  input  logic [4:0]            REG_WRITE_ADDR_S2,
  input  logic [4:0]            ALU_SELECT_S2,
  input  logic [3:0]            BRANCH_JUMP_S2,
  input  logic                  MEM_READ_S2,
  input  logic                  MEM_WRITE_S2,
  input  logic [2:0]            MEM_SIZE_S2,
  input  logic [1:0]            WB_SEL_S2,
  input  logic                  REG_WRITE_EN_S2,
  input  logic                  VALID_S2,
  input  logic                  LOAD_USE_HAZARD,
  input  logic                  FLUSH,
  input  logic                  HOLD,
  output logic [DATA_WIDTH-1:0] PC_S3,
  output logic [DATA_WIDTH-1:0] DATA1_S3,
  output logic [DATA_WIDTH-1:0] DATA2_S3,
  output logic [DATA_WIDTH-1:0] IMM_S3,
  output logic [4:0]            ADDR1_S3,
  output logic [4:0]            ADDR2_S3,
  output logic [4:0]            REG_WRITE_ADDR_S3,
  output logic [4:0]            ALU_SELECT_S3,
  output logic [3:0]            BRANCH_JUMP_S3,
  output logic                  MEM_READ_S3,
  output logic                  MEM_WRITE_S3,
  output logic [2:0]            MEM_SIZE_S3,
  output logic [1:0]            WB_SEL_S3,
  output logic                  REG_WRITE_EN_S3,
  output logic                  VALID_S3,
  output logic                  FLUSH_PENDING,
  output logic [CNT_WIDTH-1:0]  BUBBLE_COUNT,
  output logic [CNT_WIDTH-1:0]  FLUSH_COUNT,
  output logic [CNT_WIDTH-1:0]  HOLD_COUNT
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                  flush_take_p0;
  logic                  bubble_p0;
  logic                  side_en_p0;
  logic [DATA_WIDTH-1:0] pc_p0;
  logic [DATA_WIDTH-1:0] data1_p0;
  logic [DATA_WIDTH-1:0] data2_p0;
  logic [DATA_WIDTH-1:0] imm_p0;
  logic [4:0]            addr1_p0;
  logic [4:0]            addr2_p0;
  logic [4:0]            rd_p0;
  logic [4:0]            alu_p0;
  logic [3:0]            bj_p0;
  logic                  mem_rd_p0;
  logic                  mem_wr_p0;
  logic [2:0]            mem_size_p0;
  logic [1:0]            wb_sel_p0;
  logic                  reg_we_p0;
  logic                  vld_p0;

  // S2 -> S3 next-value selection (only used when HOLD is low)
  always_comb begin
    flush_take_p0 = FLUSH | FLUSH_PENDING;
    bubble_p0     = flush_take_p0 | LOAD_USE_HAZARD;
    side_en_p0    = ~bubble_p0 & VALID_S2;
    pc_p0         = bubble_p0 ? '0 : PC_S2;
    data1_p0      = bubble_p0 ? '0 : DATA1_S2;
    data2_p0      = bubble_p0 ? '0 : DATA2_S2;
    imm_p0        = bubble_p0 ? '0 : IMM_S2;
    addr1_p0      = bubble_p0 ? '0 : ADDR1_S2;
    addr2_p0      = bubble_p0 ? '0 : ADDR2_S2;
    rd_p0         = bubble_p0 ? '0 : REG_WRITE_ADDR_S2;
    alu_p0        = bubble_p0 ? '0 : ALU_SELECT_S2;
    mem_size_p0   = bubble_p0 ? '0 : MEM_SIZE_S2;
    wb_sel_p0     = bubble_p0 ? '0 : WB_SEL_S2;
    // Invalid slots keep their fields but may not cause side effects
    bj_p0         = side_en_p0 ? BRANCH_JUMP_S2 : 4'd0;
    mem_rd_p0     = side_en_p0 & MEM_READ_S2;
    mem_wr_p0     = side_en_p0 & MEM_WRITE_S2;
    reg_we_p0     = side_en_p0 & REG_WRITE_EN_S2;
    vld_p0        = side_en_p0;
  end

  // S3 register stage
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PC_S3             <= '0;
      DATA1_S3          <= '0;
      DATA2_S3          <= '0;
      IMM_S3            <= '0;
      ADDR1_S3          <= '0;
      ADDR2_S3          <= '0;
      REG_WRITE_ADDR_S3 <= '0;
      ALU_SELECT_S3     <= '0;
      BRANCH_JUMP_S3    <= '0;
      MEM_READ_S3       <= 1'b0;
      MEM_WRITE_S3      <= 1'b0;
      MEM_SIZE_S3       <= '0;
      WB_SEL_S3         <= '0;
      REG_WRITE_EN_S3   <= 1'b0;
      VALID_S3          <= 1'b0;
    end else if (!HOLD) begin
      PC_S3             <= pc_p0;
      DATA1_S3          <= data1_p0;
      DATA2_S3          <= data2_p0;
      IMM_S3            <= imm_p0;
      ADDR1_S3          <= addr1_p0;
      ADDR2_S3          <= addr2_p0;
      REG_WRITE_ADDR_S3 <= rd_p0;
      ALU_SELECT_S3     <= alu_p0;
      BRANCH_JUMP_S3    <= bj_p0;
      MEM_READ_S3       <= mem_rd_p0;
      MEM_WRITE_S3      <= mem_wr_p0;
      MEM_SIZE_S3       <= mem_size_p0;
      WB_SEL_S3         <= wb_sel_p0;
      REG_WRITE_EN_S3   <= reg_we_p0;
      VALID_S3          <= vld_p0;
    end
  end

  // Control state: deferred flush and event counters (one increment per edge at most)
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      FLUSH_PENDING <= 1'b0;
      BUBBLE_COUNT  <= '0;
      FLUSH_COUNT   <= '0;
      HOLD_COUNT    <= '0;
    end else if (HOLD) begin
      if (FLUSH) FLUSH_PENDING <= 1'b1;
      HOLD_COUNT <= sat_inc(HOLD_COUNT);
    end else if (flush_take_p0) begin
      FLUSH_PENDING <= 1'b0;
      FLUSH_COUNT   <= sat_inc(FLUSH_COUNT);
    end else if (LOAD_USE_HAZARD) begin
      BUBBLE_COUNT <= sat_inc(BUBBLE_COUNT);
    end
  end

endmodule

// File: tb/tb_pipeline_reg_s2_s3.sv
// Directed and randomized checks of the ID/EX register against a field-level reference model.
module tb_pipeline_reg_s2_s3;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] imm;
    logic [4:0]    a1;
    logic [4:0]    a2;
    logic [4:0]    rd;
    logic [4:0]    alu;
    logic [3:0]    bj;
    logic          mr;
    logic          mw;
    logic [2:0]    ms;
    logic [1:0]    wb;
    logic          we;
    logic          valid;
  } fields_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic LOAD_USE_HAZARD = 1'b0, FLUSH = 1'b0, HOLD = 1'b0;
  fields_t in = '0;
  fields_t obs;

  logic [DW-1:0] PC_S3, DATA1_S3, DATA2_S3, IMM_S3;
  logic [4:0] ADDR1_S3, ADDR2_S3, REG_WRITE_ADDR_S3, ALU_SELECT_S3;
  logic [3:0] BRANCH_JUMP_S3;
  logic MEM_READ_S3, MEM_WRITE_S3, REG_WRITE_EN_S3, VALID_S3, FLUSH_PENDING;
  logic [2:0] MEM_SIZE_S3;
  logic [1:0] WB_SEL_S3;
  logic [CW-1:0] BUBBLE_COUNT, FLUSH_COUNT, HOLD_COUNT;

  fields_t exp_f;
  logic    exp_pend;
  int      exp_bc, exp_fc, exp_hc;
  int      checks = 0;
  int      errors = 0;

  always #5 CLK = ~CLK;

  pipeline_reg_s2_s3 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .PC_S2(in.pc), .DATA1_S2(in.d1), .DATA2_S2(in.d2), .IMM_S2(in.imm),
    .ADDR1_S2(in.a1), .ADDR2_S2(in.a2), .REG_WRITE_ADDR_S2(in.rd),
    .ALU_SELECT_S2(in.alu), .BRANCH_JUMP_S2(in.bj),
    .MEM_READ_S2(in.mr), .MEM_WRITE_S2(in.mw), .MEM_SIZE_S2(in.ms),
    .WB_SEL_S2(in.wb), .REG_WRITE_EN_S2(in.we), .VALID_S2(in.valid),
    .LOAD_USE_HAZARD(LOAD_USE_HAZARD), .FLUSH(FLUSH), .HOLD(HOLD),
    .PC_S3(PC_S3), .DATA1_S3(DATA1_S3), .DATA2_S3(DATA2_S3), .IMM_S3(IMM_S3),
    .ADDR1_S3(ADDR1_S3), .ADDR2_S3(ADDR2_S3), .REG_WRITE_ADDR_S3(REG_WRITE_ADDR_S3),
    .ALU_SELECT_S3(ALU_SELECT_S3), .BRANCH_JUMP_S3(BRANCH_JUMP_S3),
    .MEM_READ_S3(MEM_READ_S3), .MEM_WRITE_S3(MEM_WRITE_S3), .MEM_SIZE_S3(MEM_SIZE_S3),
    .WB_SEL_S3(WB_SEL_S3), .REG_WRITE_EN_S3(REG_WRITE_EN_S3), .VALID_S3(VALID_S3),
    .FLUSH_PENDING(FLUSH_PENDING),
    .BUBBLE_COUNT(BUBBLE_COUNT), .FLUSH_COUNT(FLUSH_COUNT), .HOLD_COUNT(HOLD_COUNT)
  );

  assign obs = {PC_S3, DATA1_S3, DATA2_S3, IMM_S3, ADDR1_S3, ADDR2_S3, REG_WRITE_ADDR_S3,
                ALU_SELECT_S3, BRANCH_JUMP_S3, MEM_READ_S3, MEM_WRITE_S3, MEM_SIZE_S3,
                WB_SEL_S3, REG_WRITE_EN_S3, VALID_S3};

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fields"}, 256'(obs), 256'(exp_f));
    chk({tag, ".pending"}, 256'(FLUSH_PENDING), 256'(exp_pend));
    chk({tag, ".bubble_cnt"}, 256'(BUBBLE_COUNT), 256'(exp_bc));
    chk({tag, ".flush_cnt"}, 256'(FLUSH_COUNT), 256'(exp_fc));
    chk({tag, ".hold_cnt"}, 256'(HOLD_COUNT), 256'(exp_hc));
  endtask

  task automatic model_reset();
    exp_f = '0; exp_pend = 1'b0; exp_bc = 0; exp_fc = 0; exp_hc = 0;
  endtask

  // Reference behaviour of one clock edge, written from the priority rules
  task automatic model_edge();
    if (HOLD) begin
      if (exp_hc < CMAX) exp_hc++;
      if (FLUSH) exp_pend = 1'b1;
    end else if (FLUSH || exp_pend) begin
      exp_f = '0;
      exp_pend = 1'b0;
      if (exp_fc < CMAX) exp_fc++;
    end else if (LOAD_USE_HAZARD) begin
      exp_f = '0;
      if (exp_bc < CMAX) exp_bc++;
    end else begin
      exp_f = in;
      if (!in.valid) begin
        exp_f.mr = 1'b0; exp_f.mw = 1'b0; exp_f.we = 1'b0; exp_f.bj = '0;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    LOAD_USE_HAZARD = 1'b0; FLUSH = 1'b0; HOLD = 1'b0;
    in = '0;
    RESET = 1'b0;
    #1;
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    logic [191:0] r;

    // Reset state
    #3;
    model_reset();
    check_all("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // Normal flow: load at 0x100 to x5
    in = '0; in.pc = 32'h100; in.rd = 5'd5; in.mr = 1'b1; in.valid = 1'b1;
    step("normal");
    chk("normal.pc", 256'(PC_S3), 256'(32'h100));
    chk("normal.rd", 256'(REG_WRITE_ADDR_S3), 256'(5));
    chk("normal.mr", 256'(MEM_READ_S3), 256'(1));
    chk("normal.valid", 256'(VALID_S3), 256'(1));

    // Load-use bubble with ADD x6 in S2
    do_reset();
    in = '0; in.pc = 32'h104; in.rd = 5'd6; in.we = 1'b1; in.a1 = 5'd5; in.a2 = 5'd7;
    in.valid = 1'b1; in.wb = 2'd1;
    LOAD_USE_HAZARD = 1'b1;
    step("luh");
    chk("luh.valid", 256'(VALID_S3), 256'(0));
    chk("luh.we", 256'(REG_WRITE_EN_S3), 256'(0));
    chk("luh.rd", 256'(REG_WRITE_ADDR_S3), 256'(0));
    chk("luh.bc", 256'(BUBBLE_COUNT), 256'(1));
    LOAD_USE_HAZARD = 1'b0;
    step("luh_after");
    chk("luh_after.rd", 256'(REG_WRITE_ADDR_S3), 256'(6));
    chk("luh_after.valid", 256'(VALID_S3), 256'(1));

    // Hold during flush, then deferred flush on release
    do_reset();
    in = '0; in.pc = 32'h200; in.rd = 5'd9; in.we = 1'b1; in.valid = 1'b1;
    step("hf_load");
    in.pc = 32'h204;
    HOLD = 1'b1; FLUSH = 1'b1;
    step("hf_hold");
    chk("hf_hold.pc", 256'(PC_S3), 256'(32'h200));
    chk("hf_hold.pend", 256'(FLUSH_PENDING), 256'(1));
    chk("hf_hold.hc", 256'(HOLD_COUNT), 256'(1));
    HOLD = 1'b0; FLUSH = 1'b0;
    step("hf_release");
    chk("hf_release.valid", 256'(VALID_S3), 256'(0));
    chk("hf_release.pend", 256'(FLUSH_PENDING), 256'(0));
    chk("hf_release.fc", 256'(FLUSH_COUNT), 256'(1));

    // Flush beats load-use
    do_reset();
    in = '0; in.pc = 32'h300; in.rd = 5'd3; in.valid = 1'b1;
    FLUSH = 1'b1; LOAD_USE_HAZARD = 1'b1;
    step("prio");
    chk("prio.fc", 256'(FLUSH_COUNT), 256'(1));
    chk("prio.bc", 256'(BUBBLE_COUNT), 256'(0));
    FLUSH = 1'b0; LOAD_USE_HAZARD = 1'b0;

    // Invalid slot: side-effect flags suppressed, other fields pass
    in = '0; in.pc = 32'h400; in.rd = 5'd11; in.mr = 1'b1; in.mw = 1'b1; in.we = 1'b1;
    in.bj = 4'd3; in.imm = 32'hdead_beef; in.valid = 1'b0;
    step("invalid");
    chk("invalid.pc", 256'(PC_S3), 256'(32'h400));
    chk("invalid.flags", 256'({MEM_READ_S3, MEM_WRITE_S3, REG_WRITE_EN_S3, BRANCH_JUMP_S3}), 256'(0));

    // Saturation: 20 consecutive holds on a 4-bit counter
    do_reset();
    HOLD = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.hc", 256'(HOLD_COUNT), 256'(15));
    HOLD = 1'b0;

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in = fields_t'(r[$bits(fields_t)-1:0]);
      in.valid = ($urandom_range(9, 0) < 8);
      HOLD = ($urandom_range(3, 0) == 0);
      FLUSH = ($urandom_range(6, 0) == 0);
      LOAD_USE_HAZARD = ($urandom_range(4, 0) == 0);
      step("rand");
    end

    // Asynchronous reset mid-cycle with valid S3 and a pending flush
    do_reset();
    in = '0; in.pc = 32'h500; in.rd = 5'd4; in.valid = 1'b1;
    step("ar_load");
    HOLD = 1'b1; FLUSH = 1'b1;
    step("ar_hold");
    chk("ar_hold.valid", 256'(VALID_S3), 256'(1));
    chk("ar_hold.pend", 256'(FLUSH_PENDING), 256'(1));
    #2;
    RESET = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset.valid", 256'(VALID_S3), 256'(0));
    HOLD = 1'b0; FLUSH = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    step("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_reg_s2_s3.md
Name: pipeline_reg_s2_s3

Overview:
- ID/EX pipeline register of the 5-stage RV32 core: latches decoded S2 (decode) fields into S3 (execute) each cycle.
- Its outputs REG_WRITE_ADDR_S3 and MEM_READ_S3 feed the load-use hazard detector.
- Consumes that detector's LOAD_USE_HAZARD and inserts a bubble.
- Also handles branch flush and the memory-busy hold, and keeps saturating event counters for performance debug.

Parameters:
- DATA_WIDTH, 32, width of PC/operand/immediate fields
- CNT_WIDTH, 16, width of each event counter

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- PC_S2, DATA1_S2, DATA2_S2, IMM_S2  input  DATA_WIDTH each  decode-stage values
- ADDR1_S2, ADDR2_S2  input  5 each  source register addresses
- REG_WRITE_ADDR_S2  input  5  destination register address
- ALU_SELECT_S2  input  5  ALU opcode
- BRANCH_JUMP_S2  input  4  branch/jump type, 0 = none
- MEM_READ_S2, MEM_WRITE_S2  input  1 each  load / store flags
- MEM_SIZE_S2  input  3  funct3 memory width code
- WB_SEL_S2  input  2  writeback mux select
- REG_WRITE_EN_S2  input  1  register write enable
- VALID_S2  input  1  S2 holds a real instruction
- LOAD_USE_HAZARD  input  1  from the hazard detector: bubble S3
- FLUSH  input  1  branch/jump taken in S3: kill S2 instruction
- HOLD  input  1  data memory busy: freeze whole pipeline
- every *_S2 field above mirrored as *_S3  output  same width  registered copy
- VALID_S3  output  1  S3 holds a real instruction
- FLUSH_PENDING  output  1  flush deferred by HOLD
- BUBBLE_COUNT, FLUSH_COUNT, HOLD_COUNT  output  CNT_WIDTH each  saturating event counters

Behaviour:
- Reset (RESET=0, asynchronous): all *_S3 outputs 0, VALID_S3=0, FLUSH_PENDING=0, all counters 0. Deassertion is synchronous to CLK by the top level; the block needs no internal synchroniser.
- Latency: 1 cycle S2->S3 when no control input is active.
- Per-edge priority (highest first):
  1. HOLD=1: all S3 registers keep their value. If FLUSH=1, set FLUSH_PENDING. HOLD_COUNT+1.
  2. FLUSH=1 or FLUSH_PENDING=1 (HOLD=0): load a bubble, clear FLUSH_PENDING, FLUSH_COUNT+1. Count once even if both are set.
  3. LOAD_USE_HAZARD=1: load a bubble, BUBBLE_COUNT+1.
  4. Otherwise: load all *_S2 fields into *_S3 unchanged.
- Bubble definition:
  - VALID_S3=0; MEM_READ_S3, MEM_WRITE_S3, REG_WRITE_EN_S3 = 0; BRANCH_JUMP_S3=0; REG_WRITE_ADDR_S3=0.
  - All other fields zeroed as well, so a bubble is deterministic and cannot re-trigger the hazard detector.
- VALID_S2=0 with no control active: fields load as-is, but MEM_READ_S3, MEM_WRITE_S3, REG_WRITE_EN_S3 and BRANCH_JUMP_S3 are forced to 0. No side effects from invalid slots.
- LOAD_USE_HAZARD with FLUSH: flush wins; only FLUSH_COUNT increments.
- LOAD_USE_HAZARD with HOLD: hold wins, no bubble. The hazard is re-evaluated when HOLD drops.
- FLUSH_PENDING is set only while HOLD=1. It is consumed on the first HOLD=0 edge, independent of that cycle's FLUSH.
- Counters saturate at all-ones and never wrap. At most one counter increments per edge.
- Reset mid-HOLD or mid-pending-flush: everything returns to reset values immediately; no pending state survives.
- Upstream contract: the PC and IF/ID registers must also stall on LOAD_USE_HAZARD. This block does not drive those enables.

Test Plan:
- Normal flow: after reset, drive PC_S2=0x100, REG_WRITE_ADDR_S2=5, MEM_READ_S2=1, VALID_S2=1 for one cycle -> next cycle PC_S3=0x100, REG_WRITE_ADDR_S3=5, MEM_READ_S3=1, VALID_S3=1.
- Load-use bubble: LOAD_USE_HAZARD=1 for one cycle with S2 holding an ADD to x6 -> next cycle VALID_S3=0, REG_WRITE_EN_S3=0, REG_WRITE_ADDR_S3=0, BUBBLE_COUNT=1. The following cycle (hazard low) the ADD appears in S3.
- Hold during flush: HOLD=1 and FLUSH=1 on the same edge -> S3 unchanged, FLUSH_PENDING=1, HOLD_COUNT=1. Then HOLD=0, FLUSH=0 -> bubble loaded, FLUSH_PENDING=0, FLUSH_COUNT=1.
- Priority: FLUSH=1 and LOAD_USE_HAZARD=1 together -> bubble, FLUSH_COUNT=1, BUBBLE_COUNT=0.
- Saturation: CNT_WIDTH=4, 20 consecutive HOLD cycles -> HOLD_COUNT=15, no wrap.
- Asynchronous reset: assert RESET=0 mid-cycle while VALID_S3=1 and FLUSH_PENDING=1 -> outputs go to 0 before the next CLK edge; all counters read 0.
